// File: rtl/timeslice_arbiter.sv
// ---------------------------------------------------------------------------
// timeslice_arbiter
//
// Round-robin, time-sliced arbiter for one shared counter-based resource.
// Exactly one requester holds the grant at a time. The holder keeps the grant
// until it drops its request, or until its quantum of Quantum cycles expires
// while some other requester is waiting (unless hold_i suppresses preemption).
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rst_ni       : synchronous active-low reset
//   req_i        : per-requester request levels
//   hold_i       : suppresses quantum preemption while high
//   gnt_o        : one-hot grant (all zero when idle), registered
//   gnt_idx_o    : binary index of the grantee, valid while busy_o is high
//   busy_o       : a grant is active; this is also the FSM state view
//                  (0 = IDLE, 1 = GRANT)
//   slice_cnt_o  : cycles elapsed in the current slice, 0..Quantum-1
//   preempt_o    : grant is taken from a still-requesting holder at next edge
//
// Handshake: req_i is a level, not a pulse. A requester keeps its bit high
// for as long as it wants the resource and owns it exactly while its gnt_o
// bit is high; dropping the bit releases the grant at the next edge.
// ---------------------------------------------------------------------------
module timeslice_arbiter #(
    parameter  int NumReq  = 4,
    parameter  int Quantum = 8,
    localparam int IdxW    = $clog2(NumReq),
    localparam int SliceW  = $clog2(Quantum)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic              hold_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              busy_o,
    output logic [SliceW-1:0] slice_cnt_o,
    output logic              preempt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [SliceW-1:0] SliceLast = SliceW'(Quantum - 1);
    localparam logic [NumReq-1:0] OneHot0   = {{(NumReq-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [NumReq-1:0]   gnt_q, gnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [SliceW-1:0]   slice_q, slice_d;

    logic [NumReq-1:0]   others;
    logic [NumReq-1:0]   pick_mask;
    logic [IdxW-1:0]     win;
    logic                own_req;
    logic                slice_last;
    logic                do_grant;
    logic                preempt;

    // First set bit of mask searching upward from ptr+1, wrapping modulo NumReq.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] mask,
                                                input logic [IdxW-1:0]   ptr);
        logic [IdxW-1:0] pick;
        logic            found;
        int              k;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NumReq; i++) begin
            k = int'(ptr) + i;
            if (k >= NumReq) k = k - NumReq;
            if (!found && mask[k]) begin
                found = 1'b1;
                pick  = IdxW'(k);
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        slice_d    = slice_q;
        preempt    = 1'b0;
        do_grant   = 1'b0;

        own_req    = req_i[idx_q];
        others     = req_i;
        others[idx_q] = 1'b0;
        slice_last = (slice_q == SliceLast);

        // While granted the pointer equals the grantee, so searching the other
        // requesters from ptr+1 gives the round-robin successor.
        pick_mask  = (state_q == GRANT) ? others : req_i;
        win        = rr_pick(pick_mask, ptr_q);

        unique case (state_q)
            IDLE: begin
                slice_d = '0;
                if (|req_i) do_grant = 1'b1;
            end
            GRANT: begin
                if (!own_req) begin
                    // Release takes priority over quantum expiry.
                    if (|others) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        slice_d = '0;
                    end
                end else if (slice_last && (|others) && !hold_i) begin
                    preempt  = 1'b1;
                    do_grant = 1'b1;
                end else begin
                    slice_d = slice_last ? '0 : slice_q + SliceW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                slice_d = '0;
            end
        endcase

        if (do_grant) begin
            state_d = GRANT;
            gnt_d   = OneHot0 << win;
            idx_d   = win;
            ptr_d   = win;
            slice_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= IdxW'(NumReq - 1);
            slice_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            slice_q <= slice_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign busy_o      = (state_q == GRANT);
    assign slice_cnt_o = slice_q;
    assign preempt_o   = preempt;

endmodule

// File: tb/tb_timeslice_arbiter.sv
// ---------------------------------------------------------------------------
// tb_timeslice_arbiter
//
// Bench for timeslice_arbiter with NumReq=4, Quantum=4. Inputs are applied
// just after the falling edge, outputs compared 1 time unit later, and an
// integer-level reference model (owner number, pointer, elapsed cycles)
// advances once per rising edge. Directed scenarios come first, followed by
// randomized traffic with occasional hold and reset.
// ---------------------------------------------------------------------------
module tb_timeslice_arbiter;

    localparam int N = 4;
    localparam int Q = 4;

    logic         clk_i;
    logic         rst_ni;
    logic [N-1:0] req_i;
    logic         hold_i;
    logic [N-1:0] gnt_o;
    logic [1:0]   gnt_idx_o;
    logic         busy_o;
    logic [1:0]   slice_cnt_o;
    logic         preempt_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: owner = -1 means idle.
    int m_owner;
    int m_ptr;
    int m_elapsed;
    int m_idx;
    bit m_idx_known;
    bit m_valid = 1'b0;

    timeslice_arbiter #(.NumReq(N), .Quantum(Q)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .hold_i      (hold_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .busy_o      (busy_o),
        .slice_cnt_o (slice_cnt_o),
        .preempt_o   (preempt_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Round-robin choice: first requester after ptr (wrapping) in mask.
    function automatic int rr_choose(input logic [N-1:0] mask, input int ptr);
        for (int i = 1; i <= N; i++) begin
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    // ---------------- driver / model step ----------------
    task automatic step(input logic [N-1:0] req, input logic hold, input logic rst_n);
        logic [N-1:0] others;
        bit           exp_pre;
        int           exp_gnt;
        req_i  = req;
        hold_i = hold;
        rst_ni = rst_n;
        #1;
        others = req;
        if (m_owner >= 0) others[m_owner] = 1'b0;
        exp_pre = (m_owner >= 0) && (m_elapsed == Q - 1) && req[m_owner]
                  && (others != '0) && !hold;
        if (m_valid) begin
            exp_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
            check("gnt",     int'(gnt_o),       exp_gnt);
            check("busy",    int'(busy_o),      int'(m_owner >= 0));
            check("slice",   int'(slice_cnt_o), m_elapsed);
            check("preempt", int'(preempt_o),   int'(exp_pre));
            if (m_idx_known) check("gnt_idx", int'(gnt_idx_o), m_idx);
        end
        // Advance the model by one rising edge.
        if (!rst_n) begin
            m_valid     = 1'b1;
            m_owner     = -1;
            m_ptr       = N - 1;
            m_elapsed   = 0;
            m_idx       = 0;
            m_idx_known = 1'b1;
        end else if (m_valid) begin
            if (m_owner < 0) begin
                if (req != '0) begin
                    m_owner = rr_choose(req, m_ptr);
                    m_ptr = m_owner; m_idx = m_owner; m_idx_known = 1'b1; m_elapsed = 0;
                end
            end else if (!req[m_owner] || exp_pre) begin
                if (others != '0) begin
                    m_owner = rr_choose(others, m_ptr);
                    m_ptr = m_owner; m_idx = m_owner; m_idx_known = 1'b1;
                end else begin
                    m_owner = -1;
                    m_idx_known = 1'b0;
                end
                m_elapsed = 0;
            end else begin
                m_elapsed = (m_elapsed + 1) % Q;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic repeat_step(input logic [N-1:0] req, input logic hold, input int n);
        for (int i = 0; i < n; i++) step(req, hold, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    logic [N-1:0] r;
    initial begin
        rst_ni = 1'b0;
        req_i  = '0;
        hold_i = 1'b0;
        @(negedge clk_i);

        // Reset, then first arbitration among 1 and 2.
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        repeat_step(4'b0110, 1'b0, 3);
        // All requesting: full rotation with preemption pulses.
        step('0, 1'b0, 1'b0);
        repeat_step(4'b1111, 1'b0, 20);
        // Sole requester wraps its slice without preemption.
        step('0, 1'b0, 1'b0);
        repeat_step(4'b0100, 1'b0, 10);
        // Release handover then go idle.
        step('0, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b1);
        repeat_step(4'b1010, 1'b0, 2);
        step(4'b1000, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        // Hold suppresses preemption, then handover at the next boundary.
        repeat_step(4'b0011, 1'b1, 10);
        repeat_step(4'b0011, 1'b0, 8);
        // Release coinciding with quantum expiry.
        step('0, 1'b0, 1'b0);
        repeat_step(4'b0011, 1'b0, 4);
        step(4'b0010, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b1);
        // Reset mid-grant at slice 2, then re-request.
        step('0, 1'b0, 1'b1);
        repeat_step(4'b1000, 1'b0, 3);
        step(4'b1000, 1'b0, 1'b0);
        repeat_step(4'b1000, 1'b0, 3);

        // Randomized traffic.
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
            else if ($urandom_range(0, 3) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
            step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
